rr_arbiter16: RTL and testbench



---
 rtl/arb_pkg.sv | 30 +++
 rtl/dec4x16_en.sv | 36 +++
 rtl/rr_arbiter16.sv | 111 +++++++++++
 tb/tb_rr_arbiter16.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and the round-robin search function for rr_arbiter16.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Winner is the first set request after last_idx, wrapping 15 -> 0; last_idx itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last_idx);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = last_idx;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last_idx + IDX_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dec4x16_en.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module dec4x16_en
  import arb_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives onehot_o and no latch is inferred.
    onehot_o = '0;
    if (en_i) begin
      case (idx_i)
        4'd0:  onehot_o = 16'h0001;
        4'd1:  onehot_o = 16'h0002;
        4'd2:  onehot_o = 16'h0004;
        4'd3:  onehot_o = 16'h0008;
        4'd4:  onehot_o = 16'h0010;
        4'd5:  onehot_o = 16'h0020;
        4'd6:  onehot_o = 16'h0040;
        4'd7:  onehot_o = 16'h0080;
        4'd8:  onehot_o = 16'h0100;
        4'd9:  onehot_o = 16'h0200;
        4'd10: onehot_o = 16'h0400;
        4'd11: onehot_o = 16'h0800;
        4'd12: onehot_o = 16'h1000;
        4'd13: onehot_o = 16'h2000;
        4'd14: onehot_o = 16'h4000;
        4'd15: onehot_o = 16'h8000;
        default: onehot_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-client round-robin arbiter with break-before-make release.
// Optional forced release after MAX_HOLD grant cycles when HOLD_TIMEOUT_EN is defined.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);

  arb_state_e       state_q;
  logic             grant_valid_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [IDX_W-1:0] last_idx_q;

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_idx_q    <= IDX_W'(N_REQ - 1);
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_idx_q   <= rr_pick(req, last_idx_q);
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (done || !req[grant_idx_q]) begin
            grant_valid_q <= 1'b0;
            last_idx_q    <= grant_idx_q;
            state_q       <= IDLE;
          end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            grant_valid_q <= 1'b0;
            last_idx_q    <= grant_idx_q;
            timeout_q     <= 1'b1;
            state_q       <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_idx_q    <= IDX_W'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_idx_q   <= rr_pick(req, last_idx_q);
            grant_valid_q <= 1'b1;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (done || !req[grant_idx_q]) begin
            grant_valid_q <= 1'b0;
            last_idx_q    <= grant_idx_q;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold-limit parameters only matter with the timeout feature built in.
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD > 0) ^ (CNT_W > 0);
  assign timeout    = 1'b0;
`endif

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

  dec4x16_en u_dec (
    .en_i    (grant_valid_q),
    .idx_i   (grant_idx_q),
    .onehot_o(grant_onehot)
  );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed self-checking bench for rr_arbiter16 (timeout steps active when HOLD_TIMEOUT_EN is defined).
module tb_rr_arbiter16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;
  logic        timeout;

  int vectors = 0;
  int errors  = 0;

  rr_arbiter16 #(
    .MAX_HOLD(4),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all four outputs against hand-computed values.
  task automatic check_out(input string tag, input logic v, input logic [3:0] idx,
                           input logic [15:0] oh, input logic to);
    check({tag, ".valid"},   32'(grant_valid),  32'(v));
    check({tag, ".idx"},     32'(grant_idx),    32'(idx));
    check({tag, ".onehot"},  32'(grant_onehot), 32'(oh));
    check({tag, ".timeout"}, 32'(timeout),      32'(to));
  endtask

  // Advance one rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    done  = 1'b0;

    // Reset held across edges with every client requesting.
    @(negedge clk);
    check_out("rst_hold0", 1'b0, 4'd0, 16'h0000, 1'b0);
    step();
    check_out("rst_hold1", 1'b0, 4'd0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    step();
    check_out("first_grant", 1'b1, 4'd0, 16'h0001, 1'b0);
    step();
    check_out("hold_c0", 1'b1, 4'd0, 16'h0001, 1'b0);

    // Clients 0 and 15 only; release 0, expect dead cycle then 15.
    req  = 16'h8001;
    done = 1'b1;
    step();
    check_out("rel_c0", 1'b0, 4'd0, 16'h0000, 1'b0);
    done = 1'b0;
    step();
    check_out("grant_c15", 1'b1, 4'd15, 16'h8000, 1'b0);
    done = 1'b1;
    step();
    check_out("rel_c15", 1'b0, 4'd15, 16'h0000, 1'b0);
    done = 1'b0;

    // Full rotation with everyone requesting.
    req = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      step();
      check_out($sformatf("rot_g%0d", k), 1'b1, 4'(k), 16'h0001 << k, 1'b0);
      done = 1'b1;
      step();
      check_out($sformatf("rot_d%0d", k), 1'b0, 4'(k), 16'h0000, 1'b0);
      done = 1'b0;
    end
    step();
    check_out("rot_wrap", 1'b1, 4'd0, 16'h0001, 1'b0);
    done = 1'b1;
    step();
    check_out("rot_end", 1'b0, 4'd0, 16'h0000, 1'b0);
    done = 1'b0;

    // Client 5 owns; non-owner changes are ignored; dropping req[5] releases.
    req = 16'h0020;
    step();
    check_out("own_c5", 1'b1, 4'd5, 16'h0020, 1'b0);
    req = 16'h0F3F;
    step();
    check_out("c5_others", 1'b1, 4'd5, 16'h0020, 1'b0);
    req = 16'h0F1F;
    step();
    check_out("c5_drop", 1'b0, 4'd5, 16'h0000, 1'b0);
    step();
    check_out("next_c8", 1'b1, 4'd8, 16'h0100, 1'b0);

    // Single requester re-granted after exactly one dead cycle.
    req  = 16'h0100;
    done = 1'b1;
    step();
    check_out("c8_rel", 1'b0, 4'd8, 16'h0000, 1'b0);
    done = 1'b0;
    step();
    check_out("c8_regrant", 1'b1, 4'd8, 16'h0100, 1'b0);

    // Back to idle, then client 3 holds without done.
    req = 16'h0000;
    step();
    check_out("idle_c8", 1'b0, 4'd8, 16'h0000, 1'b0);
    req = 16'h0008;
    step();
    check_out("hold_c3_0", 1'b1, 4'd3, 16'h0008, 1'b0);
`ifdef HOLD_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      step();
      check_out($sformatf("hold_c3_%0d", k), 1'b1, 4'd3, 16'h0008, 1'b0);
    end
    step();
    check_out("timeout_rel", 1'b0, 4'd3, 16'h0000, 1'b1);
    step();
    check_out("timeout_regrant", 1'b1, 4'd3, 16'h0008, 1'b0);
    for (int k = 1; k < 4; k++) step();
    done = 1'b1;
    step();
    check_out("done_beats_timeout", 1'b0, 4'd3, 16'h0000, 1'b0);
    done = 1'b0;
`else
    for (int k = 1; k < 8; k++) begin
      step();
      check_out($sformatf("hold_c3_%0d", k), 1'b1, 4'd3, 16'h0008, 1'b0);
    end
`endif

    // Reset in the middle of a client-7 grant.
    req = 16'h0000;
    step();
    step();
    check_out("idle_pre7", 1'b0, 4'd3, 16'h0000, 1'b0);
    req = 16'h0080;
    step();
    check_out("own_c7", 1'b1, 4'd7, 16'h0080, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 1'b0, 4'd0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_out("post_rst_c7", 1'b1, 4'd7, 16'h0080, 1'b0);
    req = 16'h0081;
    done = 1'b1;
    step();
    check_out("post_rst_rel", 1'b0, 4'd7, 16'h0000, 1'b0);
    done = 1'b0;
    step();
    check_out("post_rst_c0", 1'b1, 4'd0, 16'h0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
